// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path types: FSM state, stall-control bundle and the opcode
// constants also used by the control decoder.
package cpu_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic no_op;
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic pipe_stall;
    } ctrl_t;

    localparam ctrl_t CTRL_FREEZE = 5'b00001;
    localparam ctrl_t CTRL_RESET  = 5'b10000;

    function automatic logic load_use(input logic       mem_read,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2);
        return mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

    // Unfrozen behaviour: a load-use bubble beats a branch flush because the
    // branch compared operands that are not yet forwarded.
    function automatic ctrl_t run_ctrl(input logic lu, input logic br_taken);
        ctrl_t c;
        c = 5'b01100;
        if (lu) begin
            c.no_op       = 1'b1;
            c.pc_write    = 1'b0;
            c.if_id_write = 1'b0;
        end else if (br_taken) begin
            c.if_id_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] ONE = 1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_o <= '0;
        else if (inc_i && (cnt_o != '1))
            cnt_o <= cnt_o + ONE;
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-flush hazard control plus memory-wait freeze with timeout
// and lost-cycle performance counters.
module hazard_stall_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_rs1_i,
    input  logic [4:0]       ID_rs2_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_rd_i,
    input  logic             ID_BranchTaken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             No_Op_o,
    output logic             PCWrite_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             pipe_stall_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WAIT_W = 16;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              err_set;
    logic              lu;
    logic              last_frz;
    ctrl_t             ctrl;

    assign lu = load_use(EX_MemRead_i, EX_rd_i, ID_rs1_i, ID_rs2_i);

    // wait_cnt holds the number of frozen cycles already completed, so this
    // cycle is the last permitted one when it makes the count reach TIMEOUT.
    assign last_frz = (({1'b0, wait_cnt} + 17'd1) >= 17'(TIMEOUT));

    always_comb begin
        ctrl      = run_ctrl(lu, ID_BranchTaken_i);
        state_nxt = state;
        wait_nxt  = '0;
        err_set   = 1'b0;
        case (state)
            RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    ctrl = CTRL_FREEZE;
                    if (last_frz)
                        err_set = 1'b1;
                    else begin
                        state_nxt = MEM_WAIT;
                        wait_nxt  = wait_cnt + 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i)
                    state_nxt = RUN;
                else begin
                    ctrl = CTRL_FREEZE;
                    if (last_frz) begin
                        state_nxt = RUN;
                        err_set   = 1'b1;
                    end else
                        wait_nxt = wait_cnt + 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (rst_i)
            ctrl = CTRL_RESET;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            mem_err_o <= mem_err_o | err_set;
        end
    end

    assign No_Op_o       = ctrl.no_op;
    assign PCWrite_o     = ctrl.pc_write;
    assign IF_ID_Write_o = ctrl.if_id_write;
    assign IF_ID_Flush_o = ctrl.if_id_flush;
    assign pipe_stall_o  = ctrl.pipe_stall;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (~ctrl.pc_write),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ctrl.if_id_flush),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scoreboard bench: the driver queues the expected outputs of each
// cycle, the monitor pops and compares them on the falling edge.
module tb_hazard_stall_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    // {no_op, pc_write, if_id_write, if_id_flush, pipe_stall}
    localparam logic [4:0] K_RUN = 5'b01100;
    localparam logic [4:0] K_BUB = 5'b10000;
    localparam logic [4:0] K_FLU = 5'b01110;
    localparam logic [4:0] K_FRZ = 5'b00001;
    localparam logic [4:0] K_RST = 5'b10000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       rs1 = '0, rs2 = '0, rd = '0;
    logic             memrd = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;
    logic             no_op, pcw, ifw, flush, stall, err;
    logic [CNT_W-1:0] scnt, fcnt;

    logic [13:0] exp_q[$];
    string       nm_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ID_rs1_i        (rs1),
        .ID_rs2_i        (rs2),
        .EX_MemRead_i    (memrd),
        .EX_rd_i         (rd),
        .ID_BranchTaken_i(br),
        .mem_req_i       (req),
        .mem_ack_i       (ack),
        .No_Op_o         (no_op),
        .PCWrite_o       (pcw),
        .IF_ID_Write_o   (ifw),
        .IF_ID_Flush_o   (flush),
        .pipe_stall_o    (stall),
        .mem_err_o       (err),
        .stall_cnt_o     (scnt),
        .flush_cnt_o     (fcnt)
    );

    function automatic logic [13:0] mk(input logic [4:0] k, input logic e,
                                       input logic [3:0] s, input logic [3:0] f);
        return {k, e, s, f};
    endfunction

    task automatic cyc(input string nm, input logic r, input logic m,
                       input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                       input logic t, input logic q, input logic k,
                       input logic [13:0] e);
        rst = r; memrd = m; rd = d; rs1 = a; rs2 = b; br = t; req = q; ack = k;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm, input logic e, input logic [3:0] s, input logic [3:0] f);
        cyc(nm, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, mk(K_RUN, e, s, f));
    endtask

    initial begin : monitor
        logic [13:0] e, got;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = nm_q.pop_front();
                got = {no_op, pcw, ifw, flush, stall, err, scnt, fcnt};
                n_chk++;
                if (got === e)
                    n_pass++;
                else
                    $display("FAIL %s: got ctl=%b err=%b stall_cnt=%0d flush_cnt=%0d, expected ctl=%b err=%b stall_cnt=%0d flush_cnt=%0d",
                             nm, got[13:9], got[8], got[7:4], got[3:0], e[13:9], e[8], e[7:4], e[3:0]);
            end
        end
    end

    initial begin : driver
        @(posedge clk);
        #1;
        cyc("reset", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, mk(K_RST, 0, 0, 0));
        idle("idle", 0, 0, 0);

        cyc("lu_rs2", 0, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0, mk(K_BUB, 0, 0, 0));
        idle("lu_rs2_after", 0, 1, 0);
        cyc("lu_rd0", 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, mk(K_RUN, 0, 1, 0));
        idle("lu_rd0_after", 0, 1, 0);
        cyc("lu_rs1", 0, 1, 5'd7, 5'd7, 5'd3, 0, 0, 0, mk(K_BUB, 0, 1, 0));
        idle("lu_rs1_after", 0, 2, 0);
        cyc("no_load", 0, 0, 5'd7, 5'd7, 5'd7, 0, 0, 0, mk(K_RUN, 0, 2, 0));

        cyc("branch", 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, mk(K_FLU, 0, 2, 0));
        idle("branch_after", 0, 2, 1);
        cyc("branch_lu", 0, 1, 5'd9, 5'd2, 5'd9, 1, 0, 0, mk(K_BUB, 0, 2, 1));
        idle("branch_lu_after", 0, 3, 1);

        cyc("ack_no_req", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, mk(K_RUN, 0, 3, 1));
        cyc("zero_wait", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, mk(K_RUN, 0, 3, 1));
        idle("zero_wait_after", 0, 3, 1);
        cyc("zero_wait_br", 0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 1, mk(K_FLU, 0, 3, 1));
        idle("zero_wait_br_after", 0, 3, 2);

        // Freeze outranks a simultaneous load-use and branch.
        cyc("wait_c1", 0, 1, 5'd5, 5'd5, 5'd0, 1, 1, 0, mk(K_FRZ, 0, 3, 2));
        cyc("wait_c2", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, mk(K_FRZ, 0, 4, 2));
        cyc("wait_c3", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, mk(K_FRZ, 0, 5, 2));
        cyc("wait_ack", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, mk(K_RUN, 0, 6, 2));
        idle("wait_after", 0, 6, 2);

        cyc("wait2_c1", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, mk(K_FRZ, 0, 6, 2));
        cyc("wait2_ack_br", 0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 1, mk(K_FLU, 0, 7, 2));
        idle("wait2_after", 0, 7, 3);

        for (int k = 1; k <= TIMEOUT; k++)
            cyc("timeout_frz", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, mk(K_FRZ, 0, 4'(6 + k), 3));
        idle("timeout_release", 1, 15, 3);
        idle("err_sticky", 1, 15, 3);

        cyc("rst_wait_c1", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, mk(K_FRZ, 1, 15, 3));
        cyc("rst_wait_c2", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, mk(K_FRZ, 1, 15, 3));
        cyc("rst_mid_wait", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, mk(K_RST, 0, 0, 0));
        idle("run_after_rst", 0, 0, 0);

        for (int k = 0; k < 20; k++)
            cyc("sat_bubble", 0, 1, 5'd5, 5'd0, 5'd5, 0, 0, 0, mk(K_BUB, 0, (k > 15) ? 4'd15 : 4'(k), 0));
        idle("sat_hold", 0, 15, 0);
        idle("sat_hold2", 0, 15, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the five-stage RISC-V core; it generates the `No_Op_i` bubble request consumed by the control decoder, together with PC/IF-ID write enables, IF-ID flush and a global pipeline freeze. It detects load-use hazards and taken-branch flushes, and sequences a variable-latency data-memory wait with timeout. Two saturating performance counters record lost cycles.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum MEM_WAIT cycles before abort (1..65535).
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `ID_rs1_i`  in  5  rs1 of the instruction in ID.
- `ID_rs2_i`  in  5  rs2 of the instruction in ID.
- `EX_MemRead_i`  in  1  the instruction in EX is a load.
- `EX_rd_i`  in  5  rd of the instruction in EX.
- `ID_BranchTaken_i`  in  1  ID branch resolved taken (Branch & equal).
- `mem_req_i`  in  1  level: MEM stage holds a load/store.
- `mem_ack_i`  in  1  one-cycle pulse: data memory completed the access.
- `No_Op_o`  out  1  bubble request to the control decoder.
- `PCWrite_o`  out  1  PC update enable.
- `IF_ID_Write_o`  out  1  IF/ID register update enable.
- `IF_ID_Flush_o`  out  1  zero the IF/ID register.
- `pipe_stall_o`  out  1  freeze all pipeline registers.
- `mem_err_o`  out  1  sticky memory-timeout flag.
- `stall_cnt_o`  out  CNT_W  saturating count of PCWrite_o=0 cycles.
- `flush_cnt_o`  out  CNT_W  saturating count of IF_ID_Flush_o=1 cycles.

## Operation
- FSM states: RUN, MEM_WAIT. Reset state RUN.
- The load-use hazard `lu` is `EX_MemRead_i & EX_rd_i!=0 & (EX_rd_i==ID_rs1_i | EX_rd_i==ID_rs2_i)`. The rs2 comparison is conservative and always applies.
- RUN, `mem_req_i & ~mem_ack_i`: go to MEM_WAIT. In the same cycle, `pipe_stall_o`=1, `PCWrite_o`=0, `IF_ID_Write_o`=0, `No_Op_o`=0 and `IF_ID_Flush_o`=0. The freeze has priority over every other hazard.
- RUN, `mem_req_i & mem_ack_i` (zero-wait access): no stall. Evaluate the next two rules.
- RUN, `lu`: `No_Op_o`=1, `PCWrite_o`=0, `IF_ID_Write_o`=0. The flush is suppressed even if `ID_BranchTaken_i`=1, because the branch operands are not yet valid.
- RUN, `~lu & ID_BranchTaken_i`: `IF_ID_Flush_o`=1. PCWrite_o and IF_ID_Write_o stay 1.
- RUN, otherwise: `PCWrite_o`=`IF_ID_Write_o`=1 and all other outputs 0.
- MEM_WAIT: outputs are held frozen as above and the wait counter increments each cycle.
  - On `mem_ack_i`: release the freeze in that same cycle and go to RUN. In that cycle the lu/branch rules apply normally.
  - When the wait counter reaches `TIMEOUT`: set `mem_err_o`, release the freeze and go to RUN. The access is dropped.
- `mem_err_o` clears only on reset.
- `stall_cnt_o` increments in every non-reset cycle with `PCWrite_o`=0. `flush_cnt_o` increments in every cycle with `IF_ID_Flush_o`=1. Both counters saturate at all-ones.

## Timing
- All control outputs are combinational from state and inputs, so they take effect in the same cycle. State, wait counter, error flag and performance counters are registered.
- Load-use costs exactly 1 bubble. On the next cycle the load has moved to MEM and `lu` drops.
- A memory access with ack on wait-cycle N stalls N cycles; ack in the request cycle stalls 0 cycles.
- Timeout: the freeze lasts exactly `TIMEOUT` cycles after entry. `mem_err_o` rises on the following edge.
- While `rst_i`=1, outputs are forced asynchronously:
  - `No_Op_o`=1, `PCWrite_o`=0, `IF_ID_Write_o`=0.
  - Flush, stall and err are 0, and both counters are 0.
  - The wait counter is 0.
- Reset asserted in MEM_WAIT aborts the wait. After deassertion the FSM is in RUN.
- A `mem_ack_i` seen in RUN without `mem_req_i` is ignored.

## Structure
- The shared package `cpu_ctrl_pkg` holds the state enum {RUN, MEM_WAIT} and the opcode constants (LOAD 0000011, STORE 0100011, BRANCH 1100011, OP_IMM 0010011, OP 0110011) shared with the control decoder.
- Sub-module `sat_counter` (parameter W; ports `inc_i`, `cnt_o`; async active-high reset) is instantiated twice for the performance counters.

## Test plan
- Load-use: `EX_MemRead_i`=1, `EX_rd_i`=5, `ID_rs2_i`=5 -> 1 cycle of `No_Op_o`=1 and `PCWrite_o`=0; `stall_cnt_o`=1. The same stimulus with `EX_rd_i`=0 -> no stall.
- Branch: `ID_BranchTaken_i`=1 with no hazard -> `IF_ID_Flush_o`=1 for 1 cycle; `flush_cnt_o`=1. Adding a simultaneous `lu` -> no flush, 1 bubble.
- Memory wait: `mem_req_i`=1 held, `mem_ack_i` pulsed on the 4th cycle -> `pipe_stall_o`=1 for 3 cycles and 0 in the ack cycle; `stall_cnt_o`=3. Zero-wait case (ack in the request cycle) -> 0 stall.
- Timeout: `TIMEOUT`=8 and no ack -> freeze for 8 cycles, then `mem_err_o`=1 and held until `rst_i`.
- Reset mid-wait: `rst_i` pulsed in the 2nd MEM_WAIT cycle -> `No_Op_o`=1 and `PCWrite_o`=0 immediately (asynchronous); counters 0; RUN after release.
- Saturation: `CNT_W`=4 with 20 stall cycles -> `stall_cnt_o` holds at 15.
